// File: rtl/speed_set_pkg.sv
// Shared constants, speed-index type and default half-period table for the speed_set divider.
package speed_set_pkg;

   localparam int NUM_SPEEDS = 32'd4;
   localparam int CNT_W      = 32'd20;
   localparam int SPEED_W    = $clog2(NUM_SPEEDS);

   typedef logic [SPEED_W-1:0] speed_idx_t;

   // clk cycles per clk_out half-period, index 0 = slowest
   localparam int HALF_DEFAULT [NUM_SPEEDS] = '{32'd500000, 32'd250000, 32'd125000, 32'd62500};

   function automatic speed_idx_t next_speed(input speed_idx_t idx);
      speed_idx_t nxt;
      if (idx == speed_idx_t'(NUM_SPEEDS - 32'sd1)) begin
         nxt = '0;
      end else begin
         nxt = idx + speed_idx_t'(32'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button level followed by a registered
// rising-edge detector; emits a one-cycle pulse three clk edges after the input rises.
module btn_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic sync1_r;
   logic sync2_r;
   logic prev_r;
   logic pulse_r;

   // synchronizer chain and registered edge pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         pulse_r <= sync2_r & ~prev_r;
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/speed_set.sv
// Programmable 50%-duty clock divider; each button press steps to the next faster speed,
// and a new speed is only adopted at a half-period boundary so clk_out never emits a runt.
module speed_set
   import speed_set_pkg::*;
#(
   parameter int HALF0 = HALF_DEFAULT[0],
   parameter int HALF1 = HALF_DEFAULT[1],
   parameter int HALF2 = HALF_DEFAULT[2],
   parameter int HALF3 = HALF_DEFAULT[3]
) (
   output logic clk_out,
   input  logic speed_toggle,
   input  logic clk,
   input  logic reset
);

   logic              press_s;
   logic              terminal_s;
   logic [CNT_W-1:0]  half_m1_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              clk_out_r;
   speed_idx_t        speed_idx_r;
   speed_idx_t        active_idx_r;

   btn_edge_sync u_btn_edge_sync (
      .clk   (clk),
      .reset (reset),
      .din   (speed_toggle),
      .pulse (press_s)
   );

   // terminal count for the speed currently driving the divider
   always_comb begin
      half_m1_s = CNT_W'(HALF0 - 32'sd1);
      case (active_idx_r)
         2'd0:    half_m1_s = CNT_W'(HALF0 - 32'sd1);
         2'd1:    half_m1_s = CNT_W'(HALF1 - 32'sd1);
         2'd2:    half_m1_s = CNT_W'(HALF2 - 32'sd1);
         2'd3:    half_m1_s = CNT_W'(HALF3 - 32'sd1);
         default: half_m1_s = CNT_W'(HALF0 - 32'sd1);
      endcase
   end

   assign terminal_s = (cnt_r == half_m1_s);

   // requested speed: advances on every synchronized press, wrapping to slowest
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         speed_idx_r <= '0;
      end else if (press_s) begin
         speed_idx_r <= next_speed(speed_idx_r);
      end else begin
         speed_idx_r <= speed_idx_r;
      end
   end

   // divider: the requested speed is latched only when a half-period completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r        <= '0;
         clk_out_r    <= 1'b0;
         active_idx_r <= '0;
      end else if (terminal_s) begin
         cnt_r        <= '0;
         clk_out_r    <= ~clk_out_r;
         active_idx_r <= speed_idx_r;
      end else begin
         cnt_r        <= cnt_r + CNT_W'(32'd1);
         clk_out_r    <= clk_out_r;
         active_idx_r <= active_idx_r;
      end
   end

   assign clk_out = clk_out_r;

endmodule

// File: tb/tb_speed_set.sv
// Directed bench for speed_set with half-periods 8,6,4,2 clks; periods 16,12,8,4.
module tb_speed_set;

   logic clk;
   logic reset;
   logic speed_toggle;
   logic clk_out;

   int pass_cnt;
   int total_cnt;

   speed_set #(
      .HALF0 (8),
      .HALF1 (6),
      .HALF2 (4),
      .HALF3 (2)
   ) dut (
      .clk_out      (clk_out),
      .speed_toggle (speed_toggle),
      .clk          (clk),
      .reset        (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts negedges until clk_out changes; -1 if it never does within the budget.
   task automatic wait_toggle(output int n);
      logic start;
      start = clk_out;
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (clk_out !== start) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_press();
      speed_toggle = 1'b1;
      repeat (4) @(negedge clk);
      speed_toggle = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (clk_out !== 1'b0) $display("FAIL reset_clk_out: got %b want 0", clk_out);
      else pass_cnt++;
      reset = 1'b0;
      wait_toggle(n);
      total_cnt++;
      if (n !== 8) $display("FAIL first_rise: got %0d clks want 8", n);
      else pass_cnt++;
   endtask

   task automatic test_speed0();
      int n;
      for (int k = 0; k < 2; k++) begin
         wait_toggle(n);
         total_cnt++;
         if (n !== 8) $display("FAIL speed0_half%0d: got %0d want 8", k, n);
         else pass_cnt++;
      end
   endtask

   task automatic test_one_press();
      int n;
      repeat (2) @(negedge clk);
      speed_toggle = 1'b1;
      fork
         begin
            repeat (10) @(negedge clk);
            speed_toggle = 1'b0;
         end
      join_none
      wait_toggle(n);
      total_cnt++;
      if (n !== 6) $display("FAIL press_no_runt: got %0d want 6", n);
      else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
         wait_toggle(n);
         total_cnt++;
         if (n !== 6) $display("FAIL speed1_half%0d: got %0d want 6", k, n);
         else pass_cnt++;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_four_presses();
      int a, b, d;
      int exp_per [4] = '{12, 8, 4, 16};
      @(negedge clk);
      pulse_reset();
      wait_toggle(a);
      wait_toggle(b);
      total_cnt++;
      if (a + b !== 16) $display("FAIL seq_period_start: got %0d want 16", a + b);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         do_press();
         wait_toggle(d);
         wait_toggle(a);
         wait_toggle(b);
         total_cnt++;
         if (a + b !== exp_per[k]) $display("FAIL seq_period%0d: got %0d want %0d", k, a + b, exp_per[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_held();
      int a, b, d;
      speed_toggle = 1'b1;
      repeat (1000) @(negedge clk);
      speed_toggle = 1'b0;
      repeat (4) @(negedge clk);
      wait_toggle(d);
      wait_toggle(a);
      wait_toggle(b);
      total_cnt++;
      if (a + b !== 12) $display("FAIL held_single_press: got period %0d want 12", a + b);
      else pass_cnt++;
   endtask

   task automatic test_bounce();
      int a, b, d;
      speed_toggle = 1'b1;
      @(negedge clk);
      speed_toggle = 1'b0;
      @(negedge clk);
      speed_toggle = 1'b1;
      @(negedge clk);
      speed_toggle = 1'b0;
      repeat (5) @(negedge clk);
      wait_toggle(d);
      wait_toggle(a);
      wait_toggle(b);
      total_cnt++;
      if (a + b !== 4) $display("FAIL bounce_two_presses: got period %0d want 4", a + b);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int  n;
      logic found;
      found = 1'b0;
      speed_toggle = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (clk_out === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      total_cnt++;
      if (found !== 1'b1) $display("FAIL mid_high_found: got %b want 1", found);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (clk_out !== 1'b0) $display("FAIL mid_reset_async: got %b want 0", clk_out);
      else pass_cnt++;
      speed_toggle = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_toggle(n);
      total_cnt++;
      if (n !== 8) $display("FAIL mid_reset_rise: got %0d want 8", n);
      else pass_cnt++;
      wait_toggle(n);
      total_cnt++;
      if (n !== 8) $display("FAIL mid_reset_half: got %0d want 8", n);
      else pass_cnt++;
   endtask

   task automatic test_coincident();
      int n;
      repeat (4) @(negedge clk);
      speed_toggle = 1'b1;
      fork
         begin
            repeat (3) @(negedge clk);
            speed_toggle = 1'b0;
         end
      join_none
      wait_toggle(n);
      total_cnt++;
      if (n !== 4) $display("FAIL coinc_remainder: got %0d want 4", n);
      else pass_cnt++;
      wait_toggle(n);
      total_cnt++;
      if (n !== 8) $display("FAIL coinc_deferred: got %0d want 8", n);
      else pass_cnt++;
      wait_toggle(n);
      total_cnt++;
      if (n !== 6) $display("FAIL coinc_applied: got %0d want 6", n);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt     = 0;
      total_cnt    = 0;
      reset        = 1'b1;
      speed_toggle = 1'b0;
      test_reset();
      test_speed0();
      test_one_press();
      test_four_presses();
      test_held();
      test_bounce();
      test_reset_mid();
      test_coincident();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
